rom_burst_reader: RTL

Fetches a burst of LANES consecutive words from an internal synchronous ROM starting at a requested base address, and presents them together as one packed response word. It replaces the earlier purely combinational multi-output ROM with a handshaked, single-read-port sequential design. It sits between the address-generating control logic and the downstream pixel/sample processing datapath.

---
 rtl/rom_burst_pkg.sv | 19 +
 rtl/rom_sync.sv | 20 ++
 rtl/rom_burst_reader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rom_burst_pkg.sv
// Shared types and defaults for the ROM burst reader: FSM state encoding,
// default widths and the lane bit-offset helper.
package rom_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } state_t;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 10;

  function automatic int lane_off(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/rom_sync.sv
// Single-port synchronous ROM with a registered output (one cycle latency).
// Contents are provided by the enclosing environment.
module rom_sync #(
  parameter int    ADDR_W   = 19,
  parameter int    DATA_W   = 16,
  parameter int    DEPTH    = 2**ADDR_W,
  parameter string MEM_FILE = "rom.hex"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Reads LANES consecutive ROM words from a base address and returns them as one
// packed word. Optional range check enabled by ROM_BURST_OOR_CHECK_EN.
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int    ADDR_W   = DEF_ADDR_W,
  parameter int    DATA_W   = DEF_DATA_W,
  parameter int    LANES    = DEF_LANES,
  parameter int    DEPTH    = 2**ADDR_W,
  parameter string MEM_FILE = "rom.hex"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [LANES*DATA_W-1:0] rsp_data,
  output logic                    rsp_err
);

  localparam int CNT_W = $clog2(LANES + 1);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  cap_cnt;
  logic              vld_p1;
  logic [ADDR_W:0]   raw_idx;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              last_cap;

  assign req_ready = (state == IDLE);
  assign last_cap  = vld_p1 && (cap_cnt == CNT_W'(LANES - 1));

  // Index is formed one bit wider than the address so base+k never overflows
  // before the modulo reduction.
  assign raw_idx  = {1'b0, base} + (ADDR_W+1)'(issue_cnt);
  assign rom_addr = ADDR_W'(raw_idx % (ADDR_W+1)'(DEPTH));

  rom_sync #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .MEM_FILE (MEM_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

`ifdef ROM_BURST_OOR_CHECK_EN
  logic              oor_p1;
  logic [ADDR_W+1:0] end_idx;

  assign end_idx = {2'b00, base} + (ADDR_W+2)'(LANES);

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_p1  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      oor_p1 <= (raw_idx >= (ADDR_W+1)'(DEPTH));
      if (state == IDLE && req_valid) begin
        rsp_err <= 1'b0;
      end else if (state == READ && last_cap) begin
        rsp_err <= (end_idx > (ADDR_W+2)'(DEPTH));
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      vld_p1    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base      <= req_addr;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            state     <= READ;
          end
        end
        READ: begin
          // Issue stage: one ROM address per cycle
          if (issue_cnt < CNT_W'(LANES)) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            vld_p1    <= 1'b1;
          end
          // Capture stage: ROM word returned for the address issued last cycle
          if (vld_p1) begin
`ifdef ROM_BURST_OOR_CHECK_EN
            rsp_data[lane_off(int'(cap_cnt), DATA_W) +: DATA_W] <= oor_p1 ? '0 : rom_data;
`else
            rsp_data[lane_off(int'(cap_cnt), DATA_W) +: DATA_W] <= rom_data;
`endif
            cap_cnt <= cap_cnt + CNT_W'(1);
          end
          if (last_cap) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
